regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised multi-entry register file. It is the next generation of the fixed 8x16 register file used by the datapath.
- Adds configurable width and depth.
- Adds an optional hardwired-zero register 0.
- Adds same-cycle write-to-read bypass.
- Adds a sequenced clear-all operation driven by an internal FSM and counter, with a Busy indication.

It sits between decode (read addresses) and writeback (write port) in the CPU datapath.

Parameters:
DATA_W, 16, width of each register and of the data ports
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 0, when 1 entry 0 always reads 0 and writes to it are discarded
BYPASS, 1, when 1 an in-flight write is forwarded to a matching read port in the same cycle

Ports:
clock  input  1  system clock, rising-edge active
resetn  input  1  asynchronous active-low reset
Read1  input  ADDR_W  read port 1 address
Read2  input  ADDR_W  read port 2 address
WriteReg  input  ADDR_W  write address
WriteData  input  DATA_W  write data
RegWrite  input  1  write enable
Clear  input  1  request clear-all (sampled only in IDLE)
Busy  output  1  high while a clear sweep is in progress
Data1  output  DATA_W  read data for Read1
Data2  output  DATA_W  read data for Read2

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clock, resetn). While resetn=0:
  - all DEPTH entries are 0;
  - FSM is IDLE, clear counter is 0, Busy=0;
  - Data1 and Data2 read 0.
- FSM states: IDLE, CLEAR. Busy = (state==CLEAR), registered.
- Effective write: we = RegWrite & (state==IDLE) & !(ZERO_REG && WriteReg==0).
  - At the rising edge with we=1: RF[WriteReg] <= WriteData.
- Reads are combinational, zero latency: DataN = RF[ReadN], subject to two overrides.
  - Priority 1: ZERO_REG=1 and ReadN==0 -> DataN = 0.
  - Priority 2: BYPASS=1 and we=1 and WriteReg==ReadN -> DataN = WriteData (same cycle, before the edge).
  - Both ports may bypass simultaneously.
- IDLE -> CLEAR when Clear=1 at a rising edge. Counter is loaded to 0.
  - If RegWrite is also high in that cycle, the write is committed first. The sweep then clears it.
- CLEAR: each rising edge performs RF[cnt] <= 0 and cnt <= cnt+1.
  - On the edge where cnt==DEPTH-1, the FSM returns to IDLE and the counter returns to 0.
  - Busy is therefore high for exactly DEPTH cycles.
- During CLEAR:
  - RegWrite is ignored; the write is dropped and not queued.
  - Bypass is disabled.
  - Clear is ignored.
  - Reads return current contents: entries below cnt already read 0, unswept entries keep old values.
- Counter width is ADDR_W. Wrap from DEPTH-1 to 0 coincides with the exit to IDLE; there is no extra cycle.
- Reset mid-sweep: all entries go to 0 immediately, FSM goes to IDLE, Busy drops asynchronously.
- Write address out of range is impossible (DEPTH = 2**ADDR_W). Read1==Read2 is legal and both ports return the same value.

Test Plan:
1. Reset and readback, defaults:
   - Apply resetn=0 -> Data1=Data2=0, Busy=0.
   - Release, write 0xA5A5 to reg 3, next cycle Read1=3 -> Data1=0xA5A5.
2. Bypass and zero register:
   - RegWrite=1, WriteReg=5, WriteData=0x1234, Read1=Read2=5 in the same cycle -> Data1=Data2=0x1234 before the edge.
   - With BYPASS=0 -> old value until after the edge.
   - ZERO_REG=1: write 0xFFFF to reg 0 -> Data1 reads 0 afterwards.
3. Clear sweep timing (DEPTH=8):
   - Preload all regs with 0x00N1.
   - Pulse Clear for 1 cycle -> Busy high for exactly 8 cycles.
   - After k sweep edges, regs 0..k-1 read 0 and reg k still reads 0x00k1.
   - After the sweep all regs read 0.
4. Write during clear:
   - RegWrite=1, WriteReg=7, WriteData=0xBEEF while Busy=1 -> dropped; reg 7 reads 0 after the sweep.
   - Clear and RegWrite (reg 7, 0xBEEF) in the same IDLE cycle -> reg 7 holds 0xBEEF until sweep step 7, then 0.
5. Reset mid-sweep and retrigger:
   - Assert resetn=0 at sweep step 3 -> Busy=0 immediately, all regs 0.
   - After release, Clear is accepted normally.
   - Clear held high continuously -> back-to-back sweeps with a single IDLE cycle between them.
6. Parameter sweep:
   - DATA_W=32, ADDR_W=5 -> Busy lasts 32 cycles.
   - Write 0xDEADBEEF to reg 31 -> readback matches, and the sweep clears it on its final step.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with optional zero register, write-to-read bypass
// and an FSM-sequenced clear-all sweep that reports Busy while it runs.
module regfile_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] Read1,
   input  logic [ADDR_W-1:0] Read2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWrite,
   input  logic              Clear,
   output logic              Busy,
   output logic [DATA_W-1:0] Data1,
   output logic [DATA_W-1:0] Data2
);
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic [DATA_W-1:0] rf [DEPTH];
   logic              we;
   // resetn gates the write so nothing is forwarded while the array is held at zero
   assign we = resetn && RegWrite && state == IDLE && !(ZERO_REG && WriteReg == '0);
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == IDLE && Clear) begin
         state_nxt = CLEAR;
         cnt_nxt   = '0;
      end else if (state == CLEAR) begin
         cnt_nxt   = cnt + 1'b1;
         state_nxt = (&cnt) ? IDLE : CLEAR;
      end
   end
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      end else if (state == CLEAR) begin
         rf[cnt] <= '0;
      end else if (we) begin
         rf[WriteReg] <= WriteData;
      end
   assign Busy  = state == CLEAR;
   assign Data1 = (ZERO_REG && Read1 == '0) ? '0 :
                  (BYPASS && we && WriteReg == Read1) ? WriteData : rf[Read1];
   assign Data2 = (ZERO_REG && Read2 == '0) ? '0 :
                  (BYPASS && we && WriteReg == Read2) ? WriteData : rf[Read2];
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: drives a default instance (8x16, bypass) and a wide instance
// (32x32, zero register, no bypass) against an array-based reference model.
module tb_regfile_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        resetn;
   logic [4:0]  r1 [2], r2 [2], wa [2];
   logic [31:0] wd [2];
   logic        we [2], clr [2];
   logic        a_busy, b_busy;
   logic [15:0] a_d1, a_d2;
   logic [31:0] b_d1, b_d2;
   int          dep [2] = '{8, 32};
   bit          zr [2]  = '{1'b0, 1'b1};
   bit          bp [2]  = '{1'b1, 1'b0};
   logic [31:0] m [2][32];
   bit          mbusy [2];
   int          mk [2];
   int          n_chk = 0, n_fail = 0;

   regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_a (
      .clock(clk), .resetn(resetn), .Read1(r1[0][2:0]), .Read2(r2[0][2:0]),
      .WriteReg(wa[0][2:0]), .WriteData(wd[0][15:0]), .RegWrite(we[0]), .Clear(clr[0]),
      .Busy(a_busy), .Data1(a_d1), .Data2(a_d2));
   regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_b (
      .clock(clk), .resetn(resetn), .Read1(r1[1]), .Read2(r2[1]),
      .WriteReg(wa[1]), .WriteData(wd[1]), .RegWrite(we[1]), .Clear(clr[1]),
      .Busy(b_busy), .Data1(b_d1), .Data2(b_d2));

   function automatic logic [31:0] o1(int d);
      return d == 0 ? {16'h0, a_d1} : b_d1;
   endfunction
   function automatic logic [31:0] o2(int d);
      return d == 0 ? {16'h0, a_d2} : b_d2;
   endfunction
   function automatic logic ob(int d);
      return d == 0 ? a_busy : b_busy;
   endfunction
   function automatic logic [31:0] msk(int d, logic [31:0] v);
      return d == 0 ? (v & 32'h0000_FFFF) : v;
   endfunction
   function automatic bit weff(int d);
      return we[d] && !mbusy[d] && !(zr[d] && wa[d] == 0);
   endfunction
   function automatic logic [31:0] exp_rd(int d, logic [4:0] a);
      if (zr[d] && a == 0) return 32'h0;
      if (bp[d] && weff(d) && wa[d] == a) return msk(d, wd[d]);
      return m[d][a];
   endfunction

   task automatic mreset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 32; i++) m[d][i] = 32'h0;
         mbusy[d] = 1'b0;
         mk[d] = 0;
      end
   endtask
   task automatic idle_in();
      for (int d = 0; d < 2; d++) begin
         we[d] = 1'b0; clr[d] = 1'b0; wa[d] = 5'd0; wd[d] = 32'h0; r1[d] = 5'd0; r2[d] = 5'd0;
      end
   endtask
   // one clock: model follows the edge, returns positioned at the next falling edge
   task automatic cyc();
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (mbusy[d]) begin
            m[d][mk[d]] = 32'h0;
            mk[d]++;
            if (mk[d] == dep[d]) begin mbusy[d] = 1'b0; mk[d] = 0; end
         end else begin
            if (weff(d)) m[d][wa[d]] = msk(d, wd[d]);
            if (clr[d]) begin mbusy[d] = 1'b1; mk[d] = 0; end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         r1[d] = 5'(d + 1); r2[d] = 5'(d + 1); wa[d] = 5'(d + 1); wd[d] = 32'hFFFF_FFFF;
         we[d] = 1'b1; clr[d] = 1'b1;
      end
      #2;
      for (int d = 0; d < 2; d++) begin
         n_chk += 3;
         if (o1(d) !== 32'h0) begin n_fail++; $display("FAIL reset_d1[%0d]: got %h exp 0", d, o1(d)); end
         if (o2(d) !== 32'h0) begin n_fail++; $display("FAIL reset_d2[%0d]: got %h exp 0", d, o2(d)); end
         if (ob(d) !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b exp 0", d, ob(d)); end
      end
      mreset();
      idle_in();
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_readback();
      we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hA5A5;
      we[1] = 1'b1; wa[1] = 5'd3; wd[1] = $urandom;
      cyc();
      idle_in();
      r1[0] = 5'd3; r1[1] = 5'd3;
      #1;
      n_chk += 2;
      if (o1(0) !== 32'hA5A5) begin n_fail++; $display("FAIL readback_a: got %h exp a5a5", o1(0)); end
      if (o1(1) !== m[1][3]) begin n_fail++; $display("FAIL readback_b: got %h exp %h", o1(1), m[1][3]); end
      cyc();
   endtask

   task automatic test_bypass();
      logic [31:0] old;
      old = m[1][5];
      for (int d = 0; d < 2; d++) begin
         we[d] = 1'b1; wa[d] = 5'd5; wd[d] = 32'h1234; r1[d] = 5'd5; r2[d] = 5'd5;
      end
      #1;
      n_chk += 3;
      if (o1(0) !== 32'h1234 || o2(0) !== 32'h1234) begin
         n_fail++; $display("FAIL bypass_both: got %h/%h exp 1234", o1(0), o2(0));
      end
      if (o1(1) !== old) begin n_fail++; $display("FAIL nobypass_pre: got %h exp %h", o1(1), old); end
      if (o2(1) !== old) begin n_fail++; $display("FAIL nobypass_pre2: got %h exp %h", o2(1), old); end
      cyc();
      we[0] = 1'b0; we[1] = 1'b0;
      #1;
      n_chk += 1;
      if (o1(1) !== 32'h1234) begin n_fail++; $display("FAIL nobypass_post: got %h exp 1234", o1(1)); end
      we[1] = 1'b1; wa[1] = 5'd0; wd[1] = 32'hFFFF; r1[1] = 5'd0;
      #1;
      n_chk += 1;
      if (o1(1) !== 32'h0) begin n_fail++; $display("FAIL zero_pre: got %h exp 0", o1(1)); end
      cyc();
      we[1] = 1'b0;
      #1;
      n_chk += 1;
      if (o1(1) !== 32'h0) begin n_fail++; $display("FAIL zero_post: got %h exp 0", o1(1)); end
      idle_in();
      cyc();
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 8; i++) begin
         we[0] = 1'b1; wa[0] = 5'(i); wd[0] = 32'(i * 16 + 1);
         cyc();
      end
      we[0] = 1'b0; clr[0] = 1'b1;
      #1;
      n_chk += 1;
      if (a_busy !== 1'b0) begin n_fail++; $display("FAIL sweep_prebusy: got %b exp 0", a_busy); end
      cyc();
      clr[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         // writes and bypass must be suppressed throughout the sweep
         we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'hBEEF;
         r1[0] = 5'(k); r2[0] = 5'(k == 0 ? 0 : k - 1);
         #1;
         n_chk += 2;
         if (a_busy !== 1'b1) begin n_fail++; $display("FAIL sweep_busy k=%0d: got %b exp 1", k, a_busy); end
         if (o1(0) !== 32'(k * 16 + 1)) begin
            n_fail++; $display("FAIL sweep_unswept k=%0d: got %h exp %h", k, o1(0), k * 16 + 1);
         end
         if (k > 0) begin
            n_chk++;
            if (o2(0) !== 32'h0) begin n_fail++; $display("FAIL sweep_swept k=%0d: got %h exp 0", k, o2(0)); end
         end
         cyc();
      end
      we[0] = 1'b0;
      #1;
      n_chk++;
      if (a_busy !== 1'b0) begin n_fail++; $display("FAIL sweep_done_busy: got %b exp 0", a_busy); end
      for (int i = 0; i < 8; i++) begin
         r1[0] = 5'(i);
         #1;
         n_chk++;
         if (o1(0) !== 32'h0) begin n_fail++; $display("FAIL sweep_cleared[%0d]: got %h exp 0", i, o1(0)); end
      end
      cyc();
   endtask

   task automatic test_clear_with_write();
      clr[0] = 1'b1; we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'hBEEF; r1[0] = 5'd7;
      #1;
      n_chk++;
      if (o1(0) !== 32'hBEEF) begin n_fail++; $display("FAIL cw_bypass: got %h exp beef", o1(0)); end
      cyc();
      clr[0] = 1'b0; we[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         n_chk++;
         if (o1(0) !== 32'hBEEF) begin n_fail++; $display("FAIL cw_hold k=%0d: got %h exp beef", k, o1(0)); end
         cyc();
      end
      #1;
      n_chk++;
      if (o1(0) !== 32'h0) begin n_fail++; $display("FAIL cw_cleared: got %h exp 0", o1(0)); end
   endtask

   task automatic test_reset_mid_sweep();
      for (int i = 0; i < 8; i++) begin
         we[0] = 1'b1; wa[0] = 5'(i); wd[0] = 32'(16'hC000 + i);
         cyc();
      end
      we[0] = 1'b0; clr[0] = 1'b1;
      cyc();
      clr[0] = 1'b0;
      repeat (3) cyc();
      #2 resetn = 1'b0;
      #1;
      n_chk++;
      if (a_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b exp 0", a_busy); end
      for (int i = 0; i < 8; i++) begin
         r1[0] = 5'(i);
         #0.25;
         n_chk++;
         if (o1(0) !== 32'h0) begin n_fail++; $display("FAIL midreset_reg[%0d]: got %h exp 0", i, o1(0)); end
      end
      mreset();
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      clr[0] = 1'b1;
      cyc();
      clr[0] = 1'b0;
      #1;
      n_chk++;
      if (a_busy !== 1'b1) begin n_fail++; $display("FAIL retrigger_busy: got %b exp 1", a_busy); end
      repeat (8) cyc();
   endtask

   task automatic test_back_to_back();
      clr[0] = 1'b1;
      cyc();
      for (int i = 0; i < 18; i++) begin
         #1;
         n_chk++;
         if (a_busy !== ((i % 9) != 8)) begin
            n_fail++; $display("FAIL b2b_busy i=%0d: got %b exp %b", i, a_busy, (i % 9) != 8);
         end
         if (i == 17) clr[0] = 1'b1;
         cyc();
      end
      clr[0] = 1'b0;
      repeat (8) cyc();
   endtask

   task automatic test_wide();
      int n;
      we[1] = 1'b1; wa[1] = 5'd31; wd[1] = 32'hDEADBEEF;
      cyc();
      we[1] = 1'b0; r1[1] = 5'd31;
      #1;
      n_chk++;
      if (o1(1) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wide_readback: got %h exp deadbeef", o1(1)); end
      clr[1] = 1'b1;
      cyc();
      clr[1] = 1'b0;
      n = 0;
      #1;
      while (b_busy === 1'b1 && n < 40) begin
         n++;
         if (n == 32) begin
            n_chk++;
            if (o1(1) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wide_last_step: got %h exp deadbeef", o1(1)); end
         end
         cyc();
         #1;
      end
      n_chk += 2;
      if (n !== 32) begin n_fail++; $display("FAIL wide_busy_len: got %0d exp 32", n); end
      if (o1(1) !== 32'h0) begin n_fail++; $display("FAIL wide_cleared: got %h exp 0", o1(1)); end
      cyc();
   endtask

   task automatic test_random();
      logic [31:0] e1, e2;
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 2; d++) begin
            we[d]  = ($urandom_range(0, 3) != 0);
            wa[d]  = 5'($urandom_range(0, dep[d] - 1));
            wd[d]  = $urandom;
            clr[d] = ($urandom_range(0, 39) == 0);
            r1[d]  = ($urandom_range(0, 2) == 0) ? wa[d] : 5'($urandom_range(0, dep[d] - 1));
            r2[d]  = ($urandom_range(0, 2) == 0) ? wa[d] : 5'($urandom_range(0, dep[d] - 1));
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            e1 = exp_rd(d, r1[d]);
            e2 = exp_rd(d, r2[d]);
            n_chk += 3;
            if (o1(d) !== e1) begin n_fail++; $display("FAIL rand_d1[%0d] c=%0d: got %h exp %h", d, c, o1(d), e1); end
            if (o2(d) !== e2) begin n_fail++; $display("FAIL rand_d2[%0d] c=%0d: got %h exp %h", d, c, o2(d), e2); end
            if (ob(d) !== mbusy[d]) begin n_fail++; $display("FAIL rand_busy[%0d] c=%0d: got %b exp %b", d, c, ob(d), mbusy[d]); end
         end
         cyc();
      end
      idle_in();
      repeat (33) cyc();
   endtask

   initial begin
      mreset();
      idle_in();
      test_reset();
      test_readback();
      test_bypass();
      test_sweep();
      test_clear_with_write();
      test_reset_mid_sweep();
      test_back_to_back();
      test_wide();
      test_random();
      test_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
